// File: rtl/vec_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : vec_alu_seq
//  Purpose  : Lane-serial vector ALU. A request is captured whole, then one
//             ELEM_WIDTH lane is computed per cycle (lane 0 first) into a
//             result register, which is presented with valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module vec_alu_seq #(
  parameter int NUM_LANES  = 8,
  parameter int ELEM_WIDTH = 32,
  parameter int REG_WIDTH  = NUM_LANES * ELEM_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [REG_WIDTH-1:0] req_a,
  input  logic [REG_WIDTH-1:0] req_b,
  input  logic [2:0]           req_op,
  input  logic                 req_use_imm,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [REG_WIDTH-1:0] resp_result,
  output logic                 resp_zero,
  output logic                 resp_err,
  output logic                 busy
);

  localparam int LW  = (NUM_LANES > 1)  ? $clog2(NUM_LANES)  : 1;
  localparam int SHW = (ELEM_WIDTH > 1) ? $clog2(ELEM_WIDTH) : 1;
  localparam logic [LW-1:0] C_LAST_LANE = LW'(NUM_LANES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [REG_WIDTH-1:0]   a_q, a_d;
  logic [REG_WIDTH-1:0]   b_q, b_d;
  logic [2:0]             op_q, op_d;
  logic                   use_imm_q, use_imm_d;
  logic [LW-1:0]          lane_q, lane_d;
  logic [REG_WIDTH-1:0]   result_q, result_d;
  logic                   err_q, err_d;

  logic [ELEM_WIDTH-1:0]  w_a_lane;
  logic [ELEM_WIDTH-1:0]  w_b_lane;
  logic [ELEM_WIDTH-1:0]  w_lane_res;
  logic                   w_accept;
  logic                   w_last_lane;

  assign w_accept    = (state_q == IDLE) && req_valid;
  assign w_last_lane = (lane_q == C_LAST_LANE);

  // Select the operands of the lane currently being computed.
  always_comb begin
    w_a_lane = '0;
    w_b_lane = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_q == LW'(i)) begin
        w_a_lane = a_q[i*ELEM_WIDTH +: ELEM_WIDTH];
        w_b_lane = b_q[i*ELEM_WIDTH +: ELEM_WIDTH];
      end
    end
    // B was already broadcast at capture; lane 0 is the immediate itself.
    if (use_imm_q) begin
      w_b_lane = b_q[ELEM_WIDTH-1:0];
    end
  end

  // Single-lane ALU; all arithmetic wraps within the lane.
  always_comb begin
    w_lane_res = '0;
    case (op_q)
      3'b000:  w_lane_res = w_a_lane + w_b_lane;
      3'b001:  w_lane_res = w_a_lane - w_b_lane;
      3'b010:  w_lane_res = b_q[ELEM_WIDTH-1:0];
      3'b011:  w_lane_res = w_a_lane * w_b_lane;
      3'b100:  w_lane_res = w_a_lane << w_b_lane[SHW-1:0];
      3'b101:  w_lane_res = {{(ELEM_WIDTH-1){1'b0}},
                             ($signed(w_a_lane) < $signed(w_b_lane))};
      default: w_lane_res = '0;
    endcase
  end

  // FSM next state and handshake/status outputs.
  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    busy        = 1'b1;
    resp_valid  = 1'b0;
    resp_zero   = 1'b0;
    resp_err    = 1'b0;
    resp_result = result_q;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_d = EXEC;
      end
      EXEC: begin
        if (w_last_lane) state_d = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_zero  = ~|result_q;
        resp_err   = err_q;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next state: capture on accept, write one lane per EXEC cycle.
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    use_imm_d = use_imm_q;
    lane_d    = lane_q;
    result_d  = result_q;
    err_d     = err_q;
    if (w_accept) begin
      a_d       = req_a;
      b_d       = req_use_imm ? {NUM_LANES{req_b[ELEM_WIDTH-1:0]}} : req_b;
      op_d      = req_op;
      use_imm_d = req_use_imm;
      lane_d    = '0;
      result_d  = '0;
      err_d     = (req_op == 3'b110) || (req_op == 3'b111);
    end else if (state_q == EXEC) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (lane_q == LW'(i)) begin
          result_d[i*ELEM_WIDTH +: ELEM_WIDTH] = w_lane_res;
        end
      end
      lane_d = w_last_lane ? '0 : lane_q + LW'(1);
    end
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      use_imm_q <= 1'b0;
      lane_q    <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      use_imm_q <= use_imm_d;
      lane_q    <= lane_d;
      result_q  <= result_d;
      err_q     <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vec_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vec_alu_seq
//  Purpose  : Self-checking bench for vec_alu_seq (directed vectors, random
//             ops against a lane-by-lane reference model, backpressure,
//             reset abandonment and back-to-back issue).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vec_alu_seq;

  localparam int NL = 8;
  localparam int RW = NL * 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [RW-1:0] req_a;
  logic [RW-1:0] req_b;
  logic [2:0]    req_op;
  logic          req_use_imm;
  logic          resp_valid;
  logic          resp_ready;
  logic [RW-1:0] resp_result;
  logic          resp_zero;
  logic          resp_err;
  logic          busy;

  int checks = 0;
  int passes = 0;

  vec_alu_seq #(.NUM_LANES(NL), .ELEM_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_use_imm(req_use_imm),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] rand_vec();
    logic [RW-1:0] v;
    for (int i = 0; i < NL; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference: per-lane model following the opcode table.
  task automatic model(input logic [RW-1:0] a, input logic [RW-1:0] b,
                       input logic [2:0] op, input logic imm,
                       output logic [RW-1:0] res, output logic err);
    logic [31:0] x, y, r;
    res = '0;
    err = (op >= 3'd6);
    for (int i = 0; i < NL; i++) begin
      x = a[i*32 +: 32];
      y = imm ? b[31:0] : b[i*32 +: 32];
      case (op)
        3'd0: r = x + y;
        3'd1: r = x - y;
        3'd2: r = b[31:0];
        3'd3: r = x * y;
        3'd4: r = x << y[4:0];
        3'd5: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        default: r = 32'd0;
      endcase
      res[i*32 +: 32] = r;
    end
  endtask

  // Issue one request, scramble inputs after accept, wait for resp_valid.
  // lat = edges from accept to first resp_valid, or -1 on timeout.
  task automatic do_op(input logic [RW-1:0] a, input logic [RW-1:0] b,
                       input logic [2:0] op, input logic imm, output int lat);
    @(negedge clk);
    resp_ready  = 1'b0;
    req_valid   = 1'b1;
    req_a       = a;
    req_b       = b;
    req_op      = op;
    req_use_imm = imm;
    @(posedge clk);
    #1;
    req_valid   = 1'b0;
    req_a       = rand_vec();
    req_b       = rand_vec();
    req_op      = 3'($urandom);
    req_use_imm = 1'($urandom);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (resp_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic finish_resp();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({req_ready, resp_valid, busy, resp_zero, resp_err} !== 5'b10000 || resp_result !== '0)
      $display("FAIL reset_idle: rdy/vld/busy/zero/err=%b result=%h, required 10000 and 0",
               {req_ready, resp_valid, busy, resp_zero, resp_err}, resp_result);
    else passes++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [RW-1:0] ta[9], tb[9], te[9];
    logic [2:0]    to[9];
    logic          ti[9], tz[9], tr[9];
    logic [RW-1:0] A0, B0;
    int lat;
    A0 = 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008;
    B0 = 256'h00000009_00000007_00000006_00000005_00000004_00000003_00000002_00000001;
    for (int i = 0; i < 6; i++) begin ta[i] = A0; tb[i] = B0; ti[i] = 0; tz[i] = 0; tr[i] = 0; end
    to[0] = 3'd0; te[0] = 256'h0000000a_00000009_00000009_00000009_00000009_00000009_00000009_00000009;
    to[1] = 3'd1; te[1] = 256'hfffffff8_fffffffb_fffffffd_ffffffff_00000001_00000003_00000005_00000007;
    to[2] = 3'd3; te[2] = 256'h00000009_0000000e_00000012_00000014_00000014_00000012_0000000e_00000008;
    to[3] = 3'd5; te[3] = 256'h00000001_00000001_00000001_00000001_00000000_00000000_00000000_00000000;
    to[4] = 3'd2; te[4] = {NL{32'h00000001}};
    to[5] = 3'd7; te[5] = '0; tz[5] = 1; tr[5] = 1;
    ta[6] = A0; tb[6] = B0; to[6] = 3'd6; ti[6] = 0; te[6] = '0; tz[6] = 1; tr[6] = 1;
    ta[7] = {NL{32'h00000001}};
    tb[7] = 256'hdeadbeef_12345678_cafef00d_0badc0de_11111111_22222222_33333333_00000004;
    to[7] = 3'd4; ti[7] = 1; te[7] = {NL{32'h00000010}}; tz[7] = 0; tr[7] = 0;
    ta[8] = '0; tb[8] = '0; to[8] = 3'd0; ti[8] = 0; te[8] = '0; tz[8] = 1; tr[8] = 0;
    for (int t = 0; t < 9; t++) begin
      do_op(ta[t], tb[t], to[t], ti[t], lat);
      checks++;
      if (lat !== NL) $display("FAIL dir%0d_latency: got %0d, required %0d", t, lat, NL);
      else passes++;
      checks++;
      if (resp_result !== te[t] || resp_zero !== tz[t] || resp_err !== tr[t])
        $display("FAIL dir%0d_result: got %h z=%b e=%b, required %h z=%b e=%b",
                 t, resp_result, resp_zero, resp_err, te[t], tz[t], tr[t]);
      else passes++;
      finish_resp();
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0)
        $display("FAIL dir%0d_return_idle: rdy=%b vld=%b busy=%b, required 1 0 0",
                 t, req_ready, resp_valid, busy);
      else passes++;
    end
  endtask

  task automatic test_random();
    logic [RW-1:0] a, b, er;
    logic [2:0] op;
    logic imm, ee;
    int lat;
    for (int t = 0; t < 24; t++) begin
      a = rand_vec();
      b = rand_vec();
      op = 3'($urandom_range(0, 7));
      imm = 1'($urandom);
      if (t % 6 == 0) b[31:0] = 32'($urandom_range(0, 31));
      model(a, b, op, imm, er, ee);
      do_op(a, b, op, imm, lat);
      checks++;
      if (lat !== NL || resp_result !== er || resp_zero !== (er == '0) || resp_err !== ee)
        $display("FAIL rand%0d op=%0d imm=%b: lat=%0d got %h z=%b e=%b, required lat=%0d %h z=%b e=%b",
                 t, op, imm, lat, resp_result, resp_zero, resp_err, NL, er, (er == '0), ee);
      else passes++;
      finish_resp();
    end
  endtask

  task automatic test_backpressure();
    logic [RW-1:0] a, b, er;
    logic ee;
    int lat;
    a = rand_vec();
    b = rand_vec();
    model(a, b, 3'd3, 1'b0, er, ee);
    do_op(a, b, 3'd3, 1'b0, lat);
    req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      req_a = rand_vec();
      checks++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || busy !== 1'b1 ||
          resp_result !== er || resp_zero !== 1'b0 || resp_err !== 1'b0)
        $display("FAIL backpressure_hold%0d: vld=%b rdy=%b result=%h z=%b e=%b, required 1 0 %h 0 0",
                 k, resp_valid, req_ready, resp_result, resp_zero, resp_err, er);
      else passes++;
    end
    // Handshake with req_valid still high: must not also accept.
    finish_resp();
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0)
      $display("FAIL no_accept_on_handshake: rdy=%b busy=%b vld=%b, required 1 0 0",
               req_ready, busy, resp_valid);
    else passes++;
    req_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [RW-1:0] a, b, er;
    logic ee;
    int lat;
    bit seen;
    // Reset at lane 3 of EXEC.
    @(negedge clk);
    req_valid = 1'b1; req_a = rand_vec(); req_b = rand_vec(); req_op = 3'd0; req_use_imm = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, busy, resp_zero, resp_err} !== 5'b10000 || resp_result !== '0)
      $display("FAIL reset_mid_exec: rdy/vld/busy/zero/err=%b result=%h, required 10000 and 0",
               {req_ready, resp_valid, busy, resp_zero, resp_err}, resp_result);
    else passes++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    resp_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 2 * NL + 4; k++) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) $display("FAIL no_resp_after_reset: resp_valid seen=%b, required 0", seen);
    else passes++;
    resp_ready = 1'b0;
    // Reset while in DONE, then accept on the first edge after release.
    do_op(rand_vec(), rand_vec(), 3'd1, 1'b0, lat);
    rst_n = 1'b0;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_result !== '0 || busy !== 1'b0)
      $display("FAIL reset_in_done: vld=%b rdy=%b busy=%b result=%h, required 0 1 0 0",
               resp_valid, req_ready, busy, resp_result);
    else passes++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    a = rand_vec();
    b = rand_vec();
    model(a, b, 3'd1, 1'b0, er, ee);
    do_op(a, b, 3'd1, 1'b0, lat);
    checks++;
    if (lat !== NL || resp_result !== er)
      $display("FAIL first_accept_after_reset: lat=%0d result=%h, required lat=%0d %h",
               lat, resp_result, NL, er);
    else passes++;
    finish_resp();
  endtask

  task automatic test_back_to_back();
    logic [RW-1:0] exp_q[$];
    logic          err_q[$];
    logic [RW-1:0] er;
    logic ee;
    int cyc, last_acc, n_acc, n_resp;
    bit prev_v, dbl;
    last_acc = -1; n_acc = 0; n_resp = 0; prev_v = 0; dbl = 0;
    resp_ready = 1'b1;
    for (cyc = 0; cyc < 5 * (NL + 2) + 24; cyc++) begin
      @(negedge clk);
      req_valid   = (cyc < 4 * (NL + 2));
      req_a       = rand_vec();
      req_b       = rand_vec();
      req_op      = 3'($urandom_range(0, 7));
      req_use_imm = 1'($urandom);
      if (req_valid && req_ready) begin
        model(req_a, req_b, req_op, req_use_imm, er, ee);
        exp_q.push_back(er);
        err_q.push_back(ee);
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc !== NL + 2)
            $display("FAIL issue_interval: got %0d, required %0d", cyc - last_acc, NL + 2);
          else passes++;
        end
        last_acc = cyc;
        n_acc++;
      end
      @(posedge clk);
      #1;
      if (resp_valid) begin
        if (prev_v) dbl = 1;
        n_resp++;
        checks++;
        if (exp_q.size() == 0)
          $display("FAIL b2b_unexpected_resp: result=%h, required no response", resp_result);
        else begin
          er = exp_q.pop_front();
          ee = err_q.pop_front();
          if (resp_result !== er || resp_err !== ee || resp_zero !== (er == '0))
            $display("FAIL b2b_result%0d: got %h e=%b z=%b, required %h e=%b z=%b",
                     n_resp, resp_result, resp_err, resp_zero, er, ee, (er == '0));
          else passes++;
        end
      end
      prev_v = resp_valid;
    end
    req_valid = 1'b0;
    resp_ready = 1'b0;
    checks++;
    if (dbl !== 1'b0) $display("FAIL resp_single_cycle: valid held >1 cycle=%b, required 0", dbl);
    else passes++;
    checks++;
    if (n_resp !== n_acc || n_acc < 4)
      $display("FAIL b2b_count: responses=%0d accepts=%0d, required equal and >=4", n_resp, n_acc);
    else passes++;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_a = '0;
    req_b = '0;
    req_op = 3'd0;
    req_use_imm = 1'b0;
    resp_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vec_alu_seq.md
VEC_ALU_SEQ -- requirements
Module: vec_alu_seq

Interface
REQ-001 The block SHALL expose parameter NUM_LANES, default 8, number of 32-bit vector lanes.
REQ-002 The block SHALL expose parameter ELEM_WIDTH, default 32, lane width in bits.
REQ-003 The block SHALL expose parameter REG_WIDTH, default NUM_LANES*ELEM_WIDTH (256), vector width.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset, named as below.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req_valid  input  1  a request is present on the request inputs.
REQ-008 req_ready  output  1  block accepts a request this cycle.
REQ-009 req_a  input  REG_WIDTH  operand vector A; lane i = bits [32i+31:32i].
REQ-010 req_b  input  REG_WIDTH  operand vector B, same lane mapping.
REQ-011 req_op  input  3  operation code (ALUControl encoding).
REQ-012 req_use_imm  input  1  when 1, B[31:0] is broadcast as the B operand of every lane.
REQ-013 resp_valid  output  1  result is valid.
REQ-014 resp_ready  input  1  consumer takes the result.
REQ-015 resp_result  output  REG_WIDTH  result vector.
REQ-016 resp_zero  output  1  1 when resp_result is all zeros.
REQ-017 resp_err  output  1  1 when req_op was reserved (110/111).
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 Opcodes SHALL be: 000 ADD, 001 SUB (A-B), 010 REPL (every lane = B lane 0), 011 MUL (low 32 bits of the product), 100 SLL (A << B[4:0]), 101 SLT (signed, lane = 1 if A<B, else 0); 110/111 reserved -> lane = 0 and resp_err = 1.
REQ-020 All lane arithmetic SHALL wrap modulo 2^32, with no carry or overflow between lanes.
REQ-021 The FSM SHALL have states IDLE, EXEC, DONE.
REQ-022 req_ready SHALL be 1 only in IDLE; a request is accepted on the edge where req_valid && req_ready.
REQ-023 On accept, the block SHALL register A, B (after the immediate broadcast), op and use_imm, clear the lane counter to 0, clear the result register, and enter EXEC.
REQ-024 In EXEC, the block SHALL compute exactly one lane per cycle, in order lane 0 to lane NUM_LANES-1, writing that lane of the result register.
REQ-025 After lane NUM_LANES-1 is written, the block SHALL enter DONE; resp_valid SHALL first be 1 on the NUM_LANES-th edge after the accept edge.
REQ-026 In DONE, resp_result, resp_zero and resp_err SHALL remain stable until the edge where resp_valid && resp_ready, after which the FSM returns to IDLE.
REQ-027 No new request SHALL be accepted in the same cycle as the response handshake; minimum issue interval is NUM_LANES+2 cycles.
REQ-028 resp_zero SHALL be computed over the full final result vector, not per lane.
REQ-029 Changes on the req_* inputs outside the accept edge SHALL NOT affect an operation in flight.
REQ-030 If resp_ready is held 1 on entry to DONE, resp_valid SHALL be high for exactly one cycle.

Reset
REQ-031 While rst_n=0, regardless of clk, the block SHALL be in IDLE with req_ready=1, resp_valid=0, busy=0, resp_result=0, resp_zero=0, resp_err=0, and the lane counter at 0.
REQ-032 Reset asserted mid-EXEC or in DONE SHALL abandon the operation, and no response SHALL be produced for it.
REQ-033 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-034 ADD: A=00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008, B=00000009_00000007_00000006_00000005_00000004_00000003_00000002_00000001 -> result 0000000a_00000009 followed by six lanes of 00000009, resp_zero=0, resp_valid 8 cycles after accept.
REQ-035 Same A/B: SUB -> fffffff8_fffffffb_fffffffd_ffffffff_00000001_00000003_00000005_00000007; MUL -> 00000009_0000000e_00000012_00000014_00000014_00000012_0000000e_00000008.
REQ-036 Same A/B: SLT -> 00000001 in lanes 7..4 and 00000000 in lanes 3..0; REPL -> all lanes 00000001; op=111 -> result 0, resp_zero=1, resp_err=1.
REQ-037 use_imm=1, B[31:0]=4, SLL, A lanes all 00000001 -> all lanes 00000010; ADD with A=0, B=0 -> resp_zero=1.
REQ-038 Backpressure and reset: hold resp_ready=0 for 5 cycles in DONE -> outputs stable and req_ready=0; pulse rst_n low at lane 3 of EXEC -> idle outputs immediately and no resp_valid afterwards.
